// File: rtl/txll_frame_fifo.sv
// Store-and-forward TX frame FIFO feeding the SATA link layer.
// Define TXLL_CUT_THROUGH_EN to let partial frames start at CUT_LEVEL words.
module txll_frame_fifo #(
    parameter int AW           = 11,
    parameter int AFULL_OFFSET = 16
`ifdef TXLL_CUT_THROUGH_EN
    ,
    parameter int CUT_LEVEL    = 256
`endif
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic [35:0]   wr_di,
    input  logic          wr_en,
    output logic          wr_full,
    output logic          wr_almost_full,
    output logic [AW:0]   wr_count,
    output logic          wr_err,
    output logic [35:0]   rd_do,
    output logic          rd_valid,
    input  logic          rd_en,
    output logic          rd_err,
    output logic          frm_rdy,
    output logic [AW:0]   frm_cnt
);

    localparam logic [AW:0] DEPTH = {1'b1, {AW{1'b0}}};
    localparam logic [AW:0] AFULL_LVL = DEPTH - (AW+1)'(AFULL_OFFSET);

    typedef enum logic {IDLE, SEND} state_t;

    state_t        state;
    state_t        state_nxt;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   cnt_nxt;
    logic [AW:0]   frm_nxt;
    logic [35:0]   head;
    logic          push;
    logic          pop;
    logic          push_eof;
    logic          pop_eof;

    logic [35:0] mem [0:(1<<AW)-1];

    assign push     = wr_en & ~wr_full;
    assign rd_valid = (state == SEND) && (wr_count != '0);
    assign pop      = rd_en & rd_valid;
    assign head     = mem[rd_ptr];
    assign rd_do    = rd_valid ? head : '0;
    assign push_eof = push & wr_di[34];
    assign pop_eof  = pop & head[34];
    assign frm_rdy  = (frm_cnt != '0);

    always_comb begin
        cnt_nxt = wr_count;
        case ({push, pop})
            2'b10:   cnt_nxt = wr_count + 1'b1;
            2'b01:   cnt_nxt = wr_count - 1'b1;
            default: cnt_nxt = wr_count;
        endcase
    end

    always_comb begin
        frm_nxt = frm_cnt;
        case ({push_eof, pop_eof})
            2'b10:   frm_nxt = frm_cnt + 1'b1;
            2'b01:   frm_nxt = frm_cnt - 1'b1;
            default: frm_nxt = frm_cnt;
        endcase
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (frm_rdy)
                    state_nxt = SEND;
`ifdef TXLL_CUT_THROUGH_EN
                // Long FIS: start draining before EOF so the FIFO cannot deadlock
                else if (wr_count >= (AW+1)'(CUT_LEVEL))
                    state_nxt = SEND;
`endif
            end
            SEND: begin
                if (pop_eof)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst || flush)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            wr_count       <= '0;
            frm_cnt        <= '0;
            wr_full        <= 1'b0;
            wr_almost_full <= 1'b0;
            wr_err         <= 1'b0;
            rd_err         <= 1'b0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            wr_count       <= cnt_nxt;
            frm_cnt        <= frm_nxt;
            wr_full        <= (cnt_nxt == DEPTH);
            wr_almost_full <= (cnt_nxt >= AFULL_LVL);
            wr_err         <= wr_en & wr_full;
            rd_err         <= rd_en & ~rd_valid;
        end
    end

    // Storage has no reset; pointers and rd_do masking hide stale words
    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= wr_di;
    end

endmodule

// File: tb/tb_txll_frame_fifo.sv
// Directed bench for txll_frame_fifo: latency, fill, frame bubbles,
// error pulses, flush, and (when enabled) cut-through draining.
module tb_txll_frame_fifo;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic [35:0] wr_di;
    logic        wr_en;
    logic        wr_full;
    logic        wr_almost_full;
    logic [11:0] wr_count;
    logic        wr_err;
    logic [35:0] rd_do;
    logic        rd_valid;
    logic        rd_en;
    logic        rd_err;
    logic        frm_rdy;
    logic [11:0] frm_cnt;

    int vectors = 0;
    int miscompares = 0;

    txll_frame_fifo dut (
        .clk(clk),
        .rst(rst),
        .flush(flush),
        .wr_di(wr_di),
        .wr_en(wr_en),
        .wr_full(wr_full),
        .wr_almost_full(wr_almost_full),
        .wr_count(wr_count),
        .wr_err(wr_err),
        .rd_do(rd_do),
        .rd_valid(rd_valid),
        .rd_en(rd_en),
        .rd_err(rd_err),
        .frm_rdy(frm_rdy),
        .frm_cnt(frm_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [35:0] wd(input logic [31:0] d,
                                       input logic sof,
                                       input logic eof);
        return {d[1], eof, d[0], sof, d};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; flush = 1'b0; wr_en = 1'b0; rd_en = 1'b0; wr_di = '0;
        tick(); tick();
        rst = 1'b0;
        vectors++;
        if (wr_count !== 12'd0 || frm_cnt !== 12'd0 || wr_full !== 1'b0 ||
            wr_almost_full !== 1'b0 || rd_valid !== 1'b0 || frm_rdy !== 1'b0 ||
            wr_err !== 1'b0 || rd_err !== 1'b0) begin
            miscompares++;
            $display("FAIL reset: cnt=%0d frm=%0d full=%b af=%b v=%b rdy=%b we=%b re=%b want all 0",
                     wr_count, frm_cnt, wr_full, wr_almost_full, rd_valid, frm_rdy, wr_err, rd_err);
        end
    endtask

    task automatic test_latency();
        for (int i = 0; i < 4; i++) begin
            wr_en = 1'b1;
            wr_di = wd(32'h1000 + i, i == 0, i == 3);
            tick();
            if (i < 3) begin
                vectors++;
                if (frm_rdy !== 1'b0) begin
                    miscompares++;
                    $display("FAIL early_frm_rdy: got %b want 0 at edge %0d", frm_rdy, i + 1);
                end
            end
        end
        wr_en = 1'b0;
        vectors++;
        if (frm_rdy !== 1'b1 || frm_cnt !== 12'd1 || rd_valid !== 1'b0 || wr_count !== 12'd4) begin
            miscompares++;
            $display("FAIL edge4: rdy=%b frm=%0d v=%b cnt=%0d want 1 1 0 4",
                     frm_rdy, frm_cnt, rd_valid, wr_count);
        end
        tick();
        vectors++;
        if (rd_valid !== 1'b1 || rd_do !== wd(32'h1000, 1'b1, 1'b0)) begin
            miscompares++;
            $display("FAIL edge5: v=%b do=%h want 1 %h", rd_valid, rd_do, wd(32'h1000, 1'b1, 1'b0));
        end
    endtask

    task automatic test_pop_frame();
        rd_en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            vectors++;
            if (rd_valid !== 1'b1 || rd_do !== wd(32'h1000 + i, i == 0, i == 3)) begin
                miscompares++;
                $display("FAIL pop%0d: v=%b do=%h want 1 %h", i, rd_valid, rd_do,
                         wd(32'h1000 + i, i == 0, i == 3));
            end
            tick();
        end
        rd_en = 1'b0;
        vectors++;
        if (rd_valid !== 1'b0 || frm_cnt !== 12'd0 || wr_count !== 12'd0 || frm_rdy !== 1'b0) begin
            miscompares++;
            $display("FAIL after_pop: v=%b frm=%0d cnt=%0d rdy=%b want 0 0 0 0",
                     rd_valid, frm_cnt, wr_count, frm_rdy);
        end
    endtask

    task automatic test_fill();
        wr_en = 1'b1;
        for (int i = 0; i < 2048; i++) begin
            wr_di = wd(i, 1'b0, 1'b0);
            tick();
            if (i + 1 == 2031 || i + 1 == 2032) begin
                vectors++;
                if (wr_almost_full !== (i + 1 == 2032) || wr_full !== 1'b0) begin
                    miscompares++;
                    $display("FAIL afull@%0d: af=%b full=%b want %b 0",
                             i + 1, wr_almost_full, wr_full, i + 1 == 2032);
                end
            end
            if (i + 1 == 2047) begin
                vectors++;
                if (wr_full !== 1'b0) begin
                    miscompares++;
                    $display("FAIL full@2047: got %b want 0", wr_full);
                end
            end
        end
        vectors++;
        if (wr_full !== 1'b1 || wr_count !== 12'd2048 || wr_err !== 1'b0 || frm_cnt !== 12'd0) begin
            miscompares++;
            $display("FAIL full@2048: full=%b cnt=%0d werr=%b frm=%0d want 1 2048 0 0",
                     wr_full, wr_count, wr_err, frm_cnt);
        end
        wr_di = wd(32'hdead, 1'b0, 1'b1);
        tick();
        wr_en = 1'b0;
        vectors++;
        if (wr_err !== 1'b1 || wr_count !== 12'd2048 || frm_cnt !== 12'd0) begin
            miscompares++;
            $display("FAIL overflow: werr=%b cnt=%0d frm=%0d want 1 2048 0", wr_err, wr_count, frm_cnt);
        end
        tick();
        vectors++;
        if (wr_err !== 1'b0) begin
            miscompares++;
            $display("FAIL werr_pulse: got %b want 0", wr_err);
        end
        flush = 1'b1;
        tick();
        flush = 1'b0;
        vectors++;
        if (wr_count !== 12'd0 || wr_full !== 1'b0 || wr_almost_full !== 1'b0 || rd_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL flush_full: cnt=%0d full=%b af=%b v=%b want 0 0 0 0",
                     wr_count, wr_full, wr_almost_full, rd_valid);
        end
    endtask

    task automatic test_back_to_back();
        logic [35:0] q [8];
        logic [35:0] c3;
        logic        ev [11];
        logic [35:0] ed [11];
        q[0] = wd(32'ha1, 1, 0); q[1] = wd(32'ha2, 0, 0); q[2] = wd(32'ha3, 0, 1);
        q[3] = wd(32'hb1, 1, 0); q[4] = wd(32'hb2, 0, 0); q[5] = wd(32'hb3, 0, 1);
        q[6] = wd(32'hc1, 1, 0); q[7] = wd(32'hc2, 0, 0);
        c3 = wd(32'hc3, 0, 1);
        ev = '{1, 1, 1, 0, 1, 1, 1, 0, 1, 1, 1};
        ed = '{q[0], q[1], q[2], '0, q[3], q[4], q[5], '0, q[6], q[7], c3};
        wr_en = 1'b1;
        for (int i = 0; i < 8; i++) begin
            wr_di = q[i];
            tick();
        end
        wr_en = 1'b0;
        vectors++;
        if (frm_cnt !== 12'd2 || wr_count !== 12'd8 || rd_valid !== 1'b1 || rd_do !== q[0]) begin
            miscompares++;
            $display("FAIL queued: frm=%0d cnt=%0d v=%b do=%h want 2 8 1 %h",
                     frm_cnt, wr_count, rd_valid, rd_do, q[0]);
        end
        rd_en = 1'b1;
        for (int k = 0; k < 11; k++) begin
            vectors++;
            if (rd_valid !== ev[k] || (ev[k] && rd_do !== ed[k])) begin
                miscompares++;
                $display("FAIL b2b_step%0d: v=%b do=%h want %b %h", k, rd_valid, rd_do, ev[k], ed[k]);
            end
            if (k == 6) begin
                wr_en = 1'b1;
                wr_di = c3;
            end
            tick();
            wr_en = 1'b0;
            if (k == 2) begin
                vectors++;
                if (frm_cnt !== 12'd1) begin
                    miscompares++;
                    $display("FAIL frm_after_a: got %0d want 1", frm_cnt);
                end
            end
            if (k == 3) begin
                vectors++;
                if (rd_err !== 1'b1) begin
                    miscompares++;
                    $display("FAIL bubble_rd_err: got %b want 1", rd_err);
                end
            end
            if (k == 6) begin
                vectors++;
                if (frm_cnt !== 12'd1 || wr_count !== 12'd3) begin
                    miscompares++;
                    $display("FAIL eof_wr_rd: frm=%0d cnt=%0d want 1 3", frm_cnt, wr_count);
                end
            end
        end
        rd_en = 1'b0;
        vectors++;
        if (frm_cnt !== 12'd0 || wr_count !== 12'd0 || rd_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL b2b_end: frm=%0d cnt=%0d v=%b want 0 0 0", frm_cnt, wr_count, rd_valid);
        end
    endtask

    task automatic test_errors_flush();
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        vectors++;
        if (rd_err !== 1'b1 || wr_count !== 12'd0 || frm_cnt !== 12'd0 || rd_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL rd_err: err=%b cnt=%0d frm=%0d v=%b want 1 0 0 0",
                     rd_err, wr_count, frm_cnt, rd_valid);
        end
        tick();
        vectors++;
        if (rd_err !== 1'b0) begin
            miscompares++;
            $display("FAIL rd_err_pulse: got %b want 0", rd_err);
        end
        wr_en = 1'b1;
        wr_di = wd(32'h51, 1, 0); tick();
        wr_di = wd(32'h52, 0, 1); tick();
        wr_di = wd(32'h61, 1, 0); tick();
        wr_en = 1'b0;
        tick();
        vectors++;
        if (rd_valid !== 1'b1 || frm_cnt !== 12'd1 || wr_count !== 12'd3) begin
            miscompares++;
            $display("FAIL pre_flush: v=%b frm=%0d cnt=%0d want 1 1 3", rd_valid, frm_cnt, wr_count);
        end
        flush = 1'b1; wr_en = 1'b1; rd_en = 1'b1;
        wr_di = wd(32'h62, 0, 1);
        tick();
        flush = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
        vectors++;
        if (wr_count !== 12'd0 || frm_cnt !== 12'd0 || rd_valid !== 1'b0 ||
            wr_err !== 1'b0 || rd_err !== 1'b0 || frm_rdy !== 1'b0) begin
            miscompares++;
            $display("FAIL flush: cnt=%0d frm=%0d v=%b we=%b re=%b rdy=%b want all 0",
                     wr_count, frm_cnt, rd_valid, wr_err, rd_err, frm_rdy);
        end
        tick();
        vectors++;
        if (wr_count !== 12'd0 || rd_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL post_flush: cnt=%0d v=%b want 0 0", wr_count, rd_valid);
        end
    endtask

`ifdef TXLL_CUT_THROUGH_EN
    task automatic test_cut_through();
        wr_en = 1'b1;
        for (int i = 0; i < 256; i++) begin
            wr_di = wd(32'h7000 + i, i == 0, 1'b0);
            tick();
        end
        wr_en = 1'b0;
        vectors++;
        if (rd_valid !== 1'b0 || wr_count !== 12'd256) begin
            miscompares++;
            $display("FAIL ct_level: v=%b cnt=%0d want 0 256", rd_valid, wr_count);
        end
        tick();
        vectors++;
        if (rd_valid !== 1'b1 || rd_do !== wd(32'h7000, 1, 0)) begin
            miscompares++;
            $display("FAIL ct_start: v=%b do=%h want 1 %h", rd_valid, rd_do, wd(32'h7000, 1, 0));
        end
        rd_en = 1'b1;
        for (int i = 0; i < 256; i++)
            tick();
        rd_en = 1'b0;
        vectors++;
        if (rd_valid !== 1'b0 || wr_count !== 12'd0) begin
            miscompares++;
            $display("FAIL ct_drain: v=%b cnt=%0d want 0 0", rd_valid, wr_count);
        end
        wr_en = 1'b1;
        wr_di = wd(32'h7100, 0, 1);
        tick();
        wr_en = 1'b0;
        vectors++;
        if (rd_valid !== 1'b1 || frm_cnt !== 12'd1 || rd_do !== wd(32'h7100, 0, 1)) begin
            miscompares++;
            $display("FAIL ct_resume: v=%b frm=%0d do=%h want 1 1 %h",
                     rd_valid, frm_cnt, rd_do, wd(32'h7100, 0, 1));
        end
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        tick();
        vectors++;
        if (rd_valid !== 1'b0 || frm_cnt !== 12'd0 || wr_count !== 12'd0) begin
            miscompares++;
            $display("FAIL ct_end: v=%b frm=%0d cnt=%0d want 0 0 0", rd_valid, frm_cnt, wr_count);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_latency();
        test_pop_frame();
        test_fill();
        test_back_to_back();
        test_errors_flush();
`ifdef TXLL_CUT_THROUGH_EN
        test_cut_through();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
